// File: rtl/uart_rx_cfg.sv
// UART receiver with run-time parity/stop-bit configuration, 3-sample majority
// voting per bit, a single-word holding register, overrun and break reporting.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8
) (
  input  logic                 sys_clk,
  input  logic                 i_rst_l,
  input  logic                 i_rx_serial,
  input  logic [1:0]           i_parity_mode,
  input  logic                 i_two_stop,
  input  logic                 i_rx_ready,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_break
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] C_LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_S0       = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] C_S1       = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] C_DEC      = CNT_W'(CLKS_PER_BIT / 2 + 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  logic                 r_rx_meta, r_rx_s;
  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_armed;
  logic                 r_smp0, r_smp1;
  logic [DATA_BITS-1:0] r_shift;
  logic [1:0]           r_par_mode;
  logic                 r_two_stop;
  logic                 r_par_bit, r_perr, r_ferr;
  logic                 r_stop0, r_stop_last, r_stop_idx;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid, r_parity_err, r_frame_err, r_overrun, r_break;

  logic w_bit, w_par_en, w_accept, w_is_break, w_bit_end, w_decide;

  assign w_bit      = (r_smp0 & r_smp1) | (r_smp0 & r_rx_s) | (r_smp1 & r_rx_s);
  assign w_par_en   = (r_par_mode == 2'b01) || (r_par_mode == 2'b10);
  assign w_accept   = r_rx_valid & i_rx_ready;
  assign w_bit_end  = (r_cnt == C_LAST);
  assign w_decide   = (r_cnt == C_DEC);
  assign w_is_break = (r_shift == '0) && (!w_par_en || !r_par_bit) && !r_stop0;

  // NOTE: synchronizer flops reset to 1 so a reset never looks like a start bit.
  always_ff @(posedge sys_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx_serial;
      r_rx_s    <= r_rx_meta;
    end
  end

  // NOTE: every state/output register uses <= so all of them update from the same pre-edge values.
  always_ff @(posedge sys_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_armed      <= 1'b0;
      r_smp0       <= 1'b1;
      r_smp1       <= 1'b1;
      r_shift      <= '0;
      r_par_mode   <= 2'b00;
      r_two_stop   <= 1'b0;
      r_par_bit    <= 1'b0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      r_stop0      <= 1'b1;
      r_stop_last  <= 1'b1;
      r_stop_idx   <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_break      <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      r_break   <= 1'b0;
      if (w_accept) r_rx_valid <= 1'b0;
      if (r_cnt == C_S0) r_smp0 <= r_rx_s;
      if (r_cnt == C_S1) r_smp1 <= r_rx_s;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (r_rx_s) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            // This cycle is count 0 of the start bit; freeze the frame format now.
            r_state    <= S_START;
            r_cnt      <= CNT_W'(1);
            r_par_mode <= i_parity_mode;
            r_two_stop <= i_two_stop;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
          end
        end

        S_START: begin
          r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
          if (w_decide && w_bit) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (w_bit_end) begin
            r_state <= S_DATA;
          end
        end

        S_DATA: begin
          r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
          if (w_decide) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
          if (w_bit_end) begin
            if (r_idx == C_IDX_LAST) r_state <= w_par_en ? S_PARITY : S_STOP;
            else                     r_idx   <= r_idx + 1'b1;
          end
        end

        S_PARITY: begin
          r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
          if (w_decide) begin
            r_par_bit <= w_bit;
            r_perr    <= ((^r_shift) ^ w_bit) != (r_par_mode == 2'b10);
          end
          if (w_bit_end) r_state <= S_STOP;
        end

        S_STOP: begin
          r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
          if (w_decide) begin
            if (!r_stop_idx) r_stop0 <= w_bit;
            if (!w_bit)      r_ferr  <= 1'b1;
            // Last stop sample ends the frame immediately.
            if (!r_two_stop || r_stop_idx) begin
              r_state     <= S_DONE;
              r_stop_last <= w_bit;
              r_cnt       <= '0;
            end
          end else if (w_bit_end) begin
            r_stop_idx <= 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_armed <= r_stop_last;
          if (w_is_break) begin
            r_break <= 1'b1;
          end else if (!r_rx_valid || i_rx_ready) begin
            r_rx_data    <= r_shift;
            r_parity_err <= r_perr;
            r_frame_err  <= r_ferr;
            r_rx_valid   <= 1'b1;
          end else begin
            r_overrun <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_rx_data    = r_rx_data;
  assign o_rx_valid   = r_rx_valid;
  assign o_parity_err = r_parity_err;
  assign o_frame_err  = r_frame_err;
  assign o_overrun    = r_overrun;
  assign o_break      = r_break;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: table vectors, randomized frames against
// a frame-level reference model, and hand sequences for overrun/break/reset.
module tb_uart_rx_cfg;

  localparam int CPB = 16;
  localparam int DW  = 8;

  logic          sys_clk = 1'b0;
  logic          i_rst_l;
  logic          i_rx_serial;
  logic [1:0]    i_parity_mode;
  logic          i_two_stop;
  logic          i_rx_ready;
  logic [DW-1:0] o_rx_data;
  logic          o_rx_valid, o_parity_err, o_frame_err, o_overrun, o_break;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(DW)) dut (
    .sys_clk      (sys_clk),
    .i_rst_l      (i_rst_l),
    .i_rx_serial  (i_rx_serial),
    .i_parity_mode(i_parity_mode),
    .i_two_stop   (i_two_stop),
    .i_rx_ready   (i_rx_ready),
    .o_rx_data    (o_rx_data),
    .o_rx_valid   (o_rx_valid),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun),
    .o_break      (o_break)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          pe;
    logic          fe;
  } word_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
    logic       two;
    logic       pbit;
    logic       s1;
    logic       s2;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_brk;
  } vec_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    valid_cycles = 0;
  int    ov_cnt   = 0;
  int    brk_cnt  = 0;
  int    rise_cyc = 0;
  int    stop_cyc = 0;
  logic  prev_valid = 1'b0;
  word_t got_q[$];
  vec_t  vecs[12];

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Monitor: samples outputs on the falling edge, records accepted words and pulses.
  always @(negedge sys_clk) begin
    if (i_rst_l) begin
      if (o_rx_valid) begin
        valid_cycles = valid_cycles + 1;
        if (!prev_valid) rise_cyc = cyc;
        if (i_rx_ready) got_q.push_back('{o_rx_data, o_parity_err, o_frame_err});
      end
      if (o_overrun) ov_cnt = ov_cnt + 1;
      if (o_break)   brk_cnt = brk_cnt + 1;
    end
    prev_valid = i_rst_l ? o_rx_valid : 1'b0;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 2 ns after a rising edge, well clear of both clock edges.
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] mode, input logic two,
                            input logic pbit, input logic s1, input logic s2, input bit scramble);
    i_parity_mode = mode;
    i_two_stop    = two;
    i_rx_serial   = 1'b0;
    tick(CPB);
    if (scramble) begin
      i_parity_mode = 2'($urandom);
      i_two_stop    = 1'($urandom);
    end
    for (int i = 0; i < DW; i++) begin
      i_rx_serial = d[i];
      tick(CPB);
    end
    if (mode == 2'b01 || mode == 2'b10) begin
      i_rx_serial = pbit;
      tick(CPB);
    end
    stop_cyc    = cyc;
    i_rx_serial = s1;
    tick(CPB);
    if (two) begin
      stop_cyc    = cyc;
      i_rx_serial = s2;
      tick(CPB);
    end
    i_rx_serial = 1'b1;
  endtask

  // Frame-level reference: what the receiver must report for one isolated frame.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    logic par_en;
    r      = v;
    par_en = (v.mode == 2'b01) || (v.mode == 2'b10);
    r.exp_brk  = (v.data == 8'h00) && (!par_en || !v.pbit) && !v.s1;
    r.exp_data = v.data;
    r.exp_perr = par_en && (((^v.data) ^ v.pbit) != (v.mode == 2'b10));
    r.exp_ferr = !v.s1 || (v.two && !v.s2);
    return r;
  endfunction

  task automatic run_frame(input string tag, input vec_t v, input bit scramble);
    int    q0, b0, v0, o0;
    word_t w;
    q0 = got_q.size();
    b0 = brk_cnt;
    v0 = valid_cycles;
    o0 = ov_cnt;
    send_frame(v.data, v.mode, v.two, v.pbit, v.s1, v.s2, scramble);
    tick(3 * CPB);
    check({tag, " overrun"}, ov_cnt - o0, 0);
    if (v.exp_brk) begin
      check({tag, " break pulses"}, brk_cnt - b0, 1);
      check({tag, " words"}, got_q.size() - q0, 0);
    end else begin
      check({tag, " break pulses"}, brk_cnt - b0, 0);
      check({tag, " words"}, got_q.size() - q0, 1);
      check({tag, " valid width"}, valid_cycles - v0, 1);
      if (got_q.size() > q0) begin
        w = got_q[q0];
        check({tag, " data"}, w.d, v.exp_data);
        check({tag, " parity_err"}, w.pe, v.exp_perr);
        check({tag, " frame_err"}, w.fe, v.exp_ferr);
        check({tag, " latency"}, rise_cyc - stop_cyc, 13);
      end
    end
  endtask

  initial begin
    vec_t  v;
    int    q0, b0, v0, o0;
    word_t w;

    //          data   mode  two   pbit  s1    s2    exp    perr  ferr  brk
    vecs[0]  = '{8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h07, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{8'h07, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'h3C, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{8'h3C, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'h00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{8'hFF, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'h80, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{8'h55, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{8'h00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{8'h00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};

    i_rst_l       = 1'b0;
    i_rx_serial   = 1'b1;
    i_parity_mode = 2'b00;
    i_two_stop    = 1'b0;
    i_rx_ready    = 1'b1;
    tick(3);
    check("reset valid", o_rx_valid, 0);
    check("reset data", o_rx_data, 0);
    check("reset flags", {o_parity_err, o_frame_err, o_overrun, o_break}, 0);
    i_rst_l = 1'b1;
    tick(5);
    check("post-reset valid", o_rx_valid, 0);

    for (int i = 0; i < 12; i++) run_frame($sformatf("vec%0d", i), vecs[i], 1'b0);

    // Randomized frames with mid-frame configuration changes.
    for (int i = 0; i < 30; i++) begin
      v.data = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      v.mode = 2'($urandom);
      v.two  = 1'($urandom);
      v.pbit = 1'($urandom);
      v.s1   = ($urandom_range(0, 5) != 0);
      v.s2   = ($urandom_range(0, 5) != 0);
      run_frame($sformatf("rand%0d", i), model(v), 1'b1);
    end

    // Overrun: consumer stalled across two frames.
    i_rx_ready = 1'b0;
    q0 = got_q.size();
    o0 = ov_cnt;
    send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(3 * CPB);
    send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(3 * CPB);
    check("ovr held valid", o_rx_valid, 1);
    check("ovr held data", o_rx_data, 8'h11);
    check("ovr pulses", ov_cnt - o0, 1);
    check("ovr words before ready", got_q.size() - q0, 0);
    i_rx_ready = 1'b1;
    tick(4);
    check("ovr words after ready", got_q.size() - q0, 1);
    if (got_q.size() > q0) begin
      w = got_q[q0];
      check("ovr accepted data", w.d, 8'h11);
    end
    check("ovr valid cleared", o_rx_valid, 0);

    // Break: line low for 20 bit times gives one pulse and no retrigger.
    q0 = got_q.size();
    b0 = brk_cnt;
    v0 = valid_cycles;
    i_rx_serial = 1'b0;
    tick(20 * CPB);
    check("brk pulses while low", brk_cnt - b0, 1);
    check("brk words", got_q.size() - q0, 0);
    check("brk valid cycles", valid_cycles - v0, 0);
    i_rx_serial = 1'b1;
    tick(2 * CPB);
    check("brk pulses after high", brk_cnt - b0, 1);
    v = '{8'h96, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h96, 1'b0, 1'b0, 1'b0};
    run_frame("after break", v, 1'b0);

    // Short low glitch is rejected as a false start.
    q0 = got_q.size();
    b0 = brk_cnt;
    v0 = valid_cycles;
    i_rx_serial = 1'b0;
    tick(5);
    i_rx_serial = 1'b1;
    tick(4 * CPB);
    check("glitch words", got_q.size() - q0, 0);
    check("glitch valid cycles", valid_cycles - v0, 0);
    check("glitch break", brk_cnt - b0, 0);
    v = '{8'hC3, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0};
    run_frame("after glitch", v, 1'b0);

    // Asynchronous reset during data bit 4 with a word held.
    i_rx_ready = 1'b0;
    send_frame(8'h33, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(3 * CPB);
    check("pre-reset held valid", o_rx_valid, 1);
    i_rx_serial = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      i_rx_serial = (i % 2 == 1);
      tick(CPB);
    end
    i_rx_serial = 1'b1;
    tick(7);
    #1;
    i_rst_l = 1'b0;
    #1;
    check("async reset valid", o_rx_valid, 0);
    check("async reset data", o_rx_data, 0);
    check("async reset flags", {o_parity_err, o_frame_err, o_overrun, o_break}, 0);
    tick(5);
    i_rst_l = 1'b1;
    q0 = got_q.size();
    b0 = brk_cnt;
    o0 = ov_cnt;
    v0 = valid_cycles;
    tick(6 * CPB);
    check("post-reset quiet valid", valid_cycles - v0, 0);
    check("post-reset quiet pulses", (brk_cnt - b0) + (ov_cnt - o0), 0);
    i_rx_ready = 1'b1;
    v = '{8'h5A, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
    run_frame("after reset", v, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLKS_PER_BIT, default 217, sys_clk cycles per bit (minimum 8).
REQ-002 Parameter DATA_BITS, default 8, data bits per frame (legal range 5..9).
REQ-003 sys_clk  input  1  system clock; all logic on the rising edge.
REQ-004 i_rst_l  input  1  reset, asynchronous, active-low.
REQ-005 i_rx_serial  input  1  asynchronous UART line, idle high.
REQ-006 i_parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-007 i_two_stop  input  1  0 = one stop bit, 1 = two stop bits.
REQ-008 i_rx_ready  input  1  consumer accepts the held word when high with o_rx_valid.
REQ-009 o_rx_data  output  DATA_BITS  received word, LSB first on line, bit 0 = first data bit.
REQ-010 o_rx_valid  output  1  held word valid; held until accepted.
REQ-011 o_parity_err  output  1  parity mismatch for the held word; valid only with o_rx_valid.
REQ-012 o_frame_err  output  1  stop bit sampled low for the held word; valid only with o_rx_valid.
REQ-013 o_overrun  output  1  one-cycle pulse: a frame completed while the holding register was still full.
REQ-014 o_break  output  1  one-cycle pulse: break frame detected.

Function
REQ-015 i_rx_serial SHALL pass through a 2-flop synchronizer; all decisions use the synchronized signal (rx_s).
REQ-016 States SHALL be IDLE, START, DATA, PARITY, STOP, DONE; undefined encodings SHALL return to IDLE.
REQ-017 The bit counter SHALL be $clog2(CLKS_PER_BIT) wide and count 0..CLKS_PER_BIT-1 per bit, where count 0 is the first cycle rx_s is seen low in IDLE.
REQ-018 Each bit value SHALL be the majority of rx_s at counts M-1, M, M+1 (M = CLKS_PER_BIT/2), decided at count M+1.
REQ-019 IDLE: arm flag set once rx_s = 1; rx_s = 0 while armed -> START, with i_parity_mode and i_two_stop latched on that cycle.
REQ-020 Config changes mid-frame SHALL NOT affect the frame in progress.
REQ-021 START: majority 1 -> false start, return to IDLE (armed stays set); majority 0 -> DATA at the end of the bit period.
REQ-022 DATA: shift in DATA_BITS samples LSB first, then go to PARITY if parity is enabled, else STOP.
REQ-023 PARITY: even mode requires XOR(data, parity bit) = 0; odd mode requires it to be 1; a mismatch sets the frame parity error.
REQ-024 STOP: sample 1 or 2 stop bits; any stop sample 0 sets the frame error.
REQ-025 After the last stop sample, the FSM SHALL go to DONE without waiting out the rest of that bit.
REQ-026 DONE (one cycle), break case: all data bits 0, parity bit 0 or disabled, and first stop bit 0 -> pulse o_break; no word delivered.
REQ-027 DONE, holding register empty (or emptied this cycle): load o_rx_data and the error flags, set o_rx_valid, then go to IDLE.
REQ-028 DONE, holding register full and not accepted this cycle: pulse o_overrun, discard the new frame, keep the held word unchanged.
REQ-029 Simultaneous accept and load: the accept of the old word and the load of the new word SHALL both occur; o_rx_valid stays 1.
REQ-030 o_rx_valid SHALL clear the cycle after i_rx_ready = 1 while valid, unless a reload occurs that same cycle.
REQ-031 Arm clears on entry to IDLE when the frame ended with a low stop bit, so a held-low line or break does not retrigger.
REQ-032 Minimum latency from the stop-bit decision to o_rx_valid = 1 SHALL be 2 cycles.

Reset
REQ-033 i_rst_l low SHALL immediately force state IDLE, arm = 0, counters 0, synchronizer flops = 1.
REQ-034 i_rst_l low SHALL immediately force o_rx_data = 0 and o_rx_valid, o_parity_err, o_frame_err, o_overrun, o_break all 0.
REQ-035 Reset mid-frame SHALL abandon the frame; after release, no output asserts until a new complete frame arrives.

Verification (CLKS_PER_BIT=16, DATA_BITS=8)
REQ-036 Parity none, one stop, send 0xA5, ready held 1 -> o_rx_data = 0xA5 with a one-cycle valid and no error flags.
REQ-037 Even parity, send 0x07 with parity bit 0 (wrong) -> data 0x07 with o_parity_err = 1; odd parity with bit 0 -> no error.
REQ-038 Two stop bits, second stop bit driven 0 -> o_frame_err = 1 with the word; next frame 0x3C received clean.
REQ-039 Ready held 0, send 0x11 then 0x22 -> 0x11 stays held and o_overrun pulses once; raising ready then shows no 0x22.
REQ-040 Line low for 20 bit times -> exactly one o_break pulse, no o_rx_valid, and no restart until the line returns high.
REQ-041 Two reset/glitch cases: a 5-cycle low glitch -> no output; reset asserted at data bit 4 -> all outputs 0, and the next 0x5A is received correctly.
